uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tranceiver among N_REQ byte-stream requesters. It grants requesters round-robin and holds the grant for a whole packet, delimited by a last flag. It sequences the transceiver's req/ready handshake, including the one-cycle lag before ready falls. It sits between the debug/status producers (hex dumpers, the sseg mirror logic) and the single board UART pin.

Parameters:
N_REQ, 4, number of requesters (2..8)
GNT_W, 2, width of grant index; must equal clog2(N_REQ)
MAX_BURST, 16, max bytes per grant before forced release (fairness cap)
HOLD_TIMEOUT, 65535, cycles a granted requester may leave valid low mid-packet before the grant is revoked
TO_W, 16, width of the timeout counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_data  in  8*N_REQ  byte from requester i at [8i+7:8i]
in_valid  in  N_REQ  requester i has a byte
in_last  in  N_REQ  byte from requester i ends its packet
in_ready  out  N_REQ  one-cycle accept strobe to requester i
tx_data  out  8  byte to transceiver data
tx_req  out  1  one-cycle load pulse to transceiver req
tx_ready  in  1  transceiver ready (high = line idle)
grant  out  GNT_W  current owner index
grant_valid  out  1  a requester currently owns the UART
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; tx_req=0; tx_data=8'h00; in_ready=0; grant_valid=0.
  - grant=0; last_gnt=N_REQ-1, so requester 0 wins first; burst_ctr=0; to_ctr=0.
- All outputs except in_ready are registered. in_ready is a combinational decode of the LOAD accept.
- IDLE: if any in_valid, pick the winner by round-robin starting at (last_gnt+1) mod N_REQ. Register grant, set grant_valid=1, go to LOAD. The arbitration cycle produces no transfer.
- LOAD:
  - Accept when in_valid[grant] && tx_ready: in_ready[grant]=1 this cycle, tx_data<=byte, tx_req<=1 at the edge, burst_ctr++, capture the last flag into pkt_end. Then go to PULSE.
  - If in_valid[grant]=0: to_ctr++. When to_ctr reaches HOLD_TIMEOUT, release to IDLE.
  - Any accept clears to_ctr.
- PULSE: tx_req is high for exactly this one cycle; it is cleared at the next edge. Go to GUARD.
- GUARD: ignore tx_ready, because the transceiver's ready lags req by one cycle. Go to WAIT.
- WAIT: stay until tx_ready=1. Then:
  - If pkt_end or burst_ctr==MAX_BURST: release to IDLE.
  - Otherwise return to LOAD with the same grant.
- Release (the IDLE entry path): last_gnt<=grant, grant_valid<=0, burst_ctr<=0, to_ctr<=0.
- Round-robin never grants the same requester twice in a row while another in_valid is high.
- Only in_ready[grant] can be high, and never outside LOAD. At most one byte is accepted per frame.
- in_valid of non-granted requesters is ignored. Requesters must hold data stable until in_ready.
- Reset mid-frame: outputs return to reset values immediately. A transceiver frame already on the line completes on its own; the arbiter restarts from IDLE and waits for tx_ready before the next LOAD accept.
- Simultaneous last and burst limit: a single release.
- MAX_BURST=1 gives byte-level round-robin.

Decomposition:
- Package uart_arb_pkg:
  - state encoding: IDLE, LOAD, PULSE, GUARD, WAIT (3-bit localparams)
  - function to extract byte i from in_data
- Sub-module rr_pick #(N_REQ, GNT_W):
  - combinational inputs req[N_REQ] and last_gnt; outputs winner index and any_req
  - rotate, priority-encode, un-rotate
  - reused later by other shared-resource controllers

Test Plan:
- Bench instantiates uart_tranceiver with CLK_CYCLES=4 alongside the arbiter.
- Single byte: r0 sends 8'h41 with last=1 -> one tx_req pulse; tx_data=8'h41; the decoded uart_tx frame is 0,1000_0010,1; grant_valid drops after tx_ready returns.
- Contention: r0 and r2 both valid from reset, each with a 2-byte packet (r0: 11,12; r2: 21,22) -> line order 11,12,21,22; grant sequence 0 then 2; no interleaving.
- Fairness: r1 streams without last, MAX_BURST=3, r3 is valid -> r1 gets 3 bytes, then r3, then r1 again.
- Ready lag: check that every tx_req is followed by at least 10*CLK_CYCLES cycles before the next tx_req, and that no tx_req occurs while tx_ready=0.
- Timeout: HOLD_TIMEOUT=20; r0 sends one byte with last=0, then drops valid -> grant released 20 cycles into LOAD; r1 is then granted.
- Reset mid-operation: assert rst_n=0 during WAIT -> tx_req=0, grant_valid=0, in_ready=0 asynchronously; after release, r0 is granted first and its byte is sent only after tx_ready is high.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related shared-resource controllers.
package uart_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PULSE = 3'd2,
    GUARD = 3'd3,
    WAIT  = 3'd4
  } arb_state_t;

  // Byte lane idx of a requester data bus zero-padded to MAX_REQ lanes.
  function automatic logic [7:0] get_byte(input logic [8*MAX_REQ-1:0] bus,
                                          input logic [2:0]           idx);
    return bus[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts one past last_gnt and wraps.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GNT_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GNT_W-1:0] last_gnt,
  output logic [GNT_W-1:0] winner,
  output logic             any_req
);

  logic [N_REQ-1:0] rot;
  logic [GNT_W-1:0] sel;
  int               idx;
  int               offset;

  // Rotate so the preferred requester sits at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    rot    = '0;
    sel    = '0;
    idx    = 0;
    offset = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(last_gnt) + 1 + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel    = GNT_W'(idx);
      rot[k] = req[sel];
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) offset = k;
    end
    idx = int'(last_gnt) + 1 + offset;
    if (idx >= N_REQ) idx = idx - N_REQ;
    winner = GNT_W'(idx);
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte streams, granting whole packets round-robin
// with a burst cap and an idle timeout, and sequencing the transceiver req/ready handshake.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GNT_W        = 2,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 65535,
  parameter int TO_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*N_REQ-1:0] in_data,
  input  logic [N_REQ-1:0]   in_valid,
  input  logic [N_REQ-1:0]   in_last,
  output logic [N_REQ-1:0]   in_ready,
  output logic [7:0]         tx_data,
  output logic               tx_req,
  input  logic               tx_ready,
  output logic [GNT_W-1:0]   grant,
  output logic               grant_valid,
  output logic               busy
);

  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_state_t           state, state_nxt;
  logic [GNT_W-1:0]     grant_nxt, last_gnt, last_gnt_nxt, winner;
  logic                 grant_valid_nxt, any_req;
  logic                 pkt_end, pkt_end_nxt;
  logic                 tx_req_nxt, accept, release_grant;
  logic [BURST_W-1:0]   burst_ctr, burst_nxt;
  logic [TO_W-1:0]      to_ctr, to_nxt;
  logic [7:0]           tx_data_nxt, cur_byte;
  logic [8*MAX_REQ-1:0] data_pad;

  rr_pick #(
    .N_REQ (N_REQ),
    .GNT_W (GNT_W)
  ) u_pick (
    .req      (in_valid),
    .last_gnt (last_gnt),
    .winner   (winner),
    .any_req  (any_req)
  );

  always_comb begin
    data_pad                = '0;
    data_pad[8*N_REQ-1:0]   = in_data;
  end

  assign cur_byte = get_byte(data_pad, 3'(grant));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      last_gnt    <= GNT_W'(N_REQ - 1);
      burst_ctr   <= '0;
      to_ctr      <= '0;
      pkt_end     <= 1'b0;
      tx_data     <= 8'h00;
      tx_req      <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_valid <= grant_valid_nxt;
      last_gnt    <= last_gnt_nxt;
      burst_ctr   <= burst_nxt;
      to_ctr      <= to_nxt;
      pkt_end     <= pkt_end_nxt;
      tx_data     <= tx_data_nxt;
      tx_req      <= tx_req_nxt;
    end
  end

  // GUARD exists because the transceiver still shows ready for one cycle after the req pulse.
  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    grant_valid_nxt = grant_valid;
    last_gnt_nxt    = last_gnt;
    burst_nxt       = burst_ctr;
    to_nxt          = to_ctr;
    pkt_end_nxt     = pkt_end;
    tx_data_nxt     = tx_data;
    tx_req_nxt      = 1'b0;
    accept          = 1'b0;
    release_grant   = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt       = winner;
          grant_valid_nxt = 1'b1;
          state_nxt       = LOAD;
        end
      end
      LOAD: begin
        if (in_valid[grant] && tx_ready) begin
          accept      = 1'b1;
          tx_data_nxt = cur_byte;
          tx_req_nxt  = 1'b1;
          burst_nxt   = burst_ctr + BURST_W'(1);
          pkt_end_nxt = in_last[grant];
          to_nxt      = '0;
          state_nxt   = PULSE;
        end else if (!in_valid[grant]) begin
          if (to_ctr == TO_W'(HOLD_TIMEOUT - 1)) begin
            release_grant = 1'b1;
          end else begin
            to_nxt = to_ctr + TO_W'(1);
          end
        end
      end
      PULSE: state_nxt = GUARD;
      GUARD: state_nxt = WAIT;
      WAIT: begin
        if (tx_ready) begin
          if (pkt_end || (burst_ctr == BURST_W'(MAX_BURST))) begin
            release_grant = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (release_grant) begin
      state_nxt       = IDLE;
      last_gnt_nxt    = grant;
      grant_valid_nxt = 1'b0;
      burst_nxt       = '0;
      to_nxt          = '0;
    end
  end

  assign in_ready = accept ? (N_REQ'(1) << grant) : '0;
  assign busy     = grant_valid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter with a behavioural transceiver,
// a line decoder and a packet-level round-robin model of the expected byte stream.
module tb_uart_tx_arbiter;

  localparam int N_REQ        = 4;
  localparam int GNT_W        = 2;
  localparam int MAX_BURST    = 3;
  localparam int HOLD_TIMEOUT = 20;
  localparam int TO_W         = 16;
  localparam int CLK_CYCLES   = 4;
  localparam int MIN_GAP      = 10 * CLK_CYCLES;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [8*N_REQ-1:0] in_data;
  logic [N_REQ-1:0]   in_valid, in_last, in_ready;
  logic [7:0]         tx_data;
  logic               tx_req, tx_ready, tx_line;
  logic [GNT_W-1:0]   grant;
  logic               grant_valid, busy;

  typedef struct packed { logic l; logic [7:0] d; } beat_t;
  typedef struct packed { logic [7:0] g; logic [7:0] d; } exp_t;

  beat_t       q [N_REQ][$];
  exp_t        expq[$];
  logic [7:0]  grant_log[$];
  logic [9:0]  frames[$];
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          last_req_cycle = -1;
  logic        prev_req = 1'b0;

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .GNT_W        (GNT_W),
    .MAX_BURST    (MAX_BURST),
    .HOLD_TIMEOUT (HOLD_TIMEOUT),
    .TO_W         (TO_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_ready    (tx_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input int r, input logic [7:0] d, input logic l);
    q[r].push_back({l, d});
  endtask

  // Packet-level model: round-robin over non-empty queues, a grant ends on last, on the burst
  // cap, or when the queue runs dry (the requester drops valid and the hold timeout fires).
  function automatic void build_expected();
    beat_t mq [N_REQ][$];
    beat_t b;
    int    last_g = N_REQ - 1;
    int    w, cnt;
    bit    found;
    for (int i = 0; i < N_REQ; i++) mq[i] = q[i];
    expq.delete();
    forever begin
      found = 1'b0;
      w     = 0;
      for (int k = 1; k <= N_REQ; k++) begin
        if (!found && mq[(last_g + k) % N_REQ].size() > 0) begin
          found = 1'b1;
          w     = (last_g + k) % N_REQ;
        end
      end
      if (!found) break;
      cnt = 0;
      do begin
        b = mq[w].pop_front();
        expq.push_back({8'(w), b.d});
        cnt++;
      end while (!b.l && cnt < MAX_BURST && mq[w].size() > 0);
      last_g = w;
    end
  endfunction

  // Transceiver: ready stays high one cycle after the req pulse, then drops for a 10-bit frame.
  initial begin : xcvr
    logic [9:0] sh;
    tx_ready = 1'b1;
    tx_line  = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_req === 1'b1 && tx_ready) begin
        sh = {1'b1, tx_data, 1'b0};
        @(posedge clk); #1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tx_line = sh[k];
          repeat (CLK_CYCLES) @(posedge clk);
          #1;
        end
        tx_line  = 1'b1;
        tx_ready = 1'b1;
      end
    end
  end

  initial begin : rx
    logic [9:0] f;
    forever begin
      @(negedge clk);
      if (tx_line == 1'b0) begin
        for (int k = 0; k < 10; k++) begin
          if (k > 0) repeat (CLK_CYCLES) @(negedge clk);
          f[k] = tx_line;
        end
        frames.push_back(f);
      end
    end
  end

  initial begin : drv
    logic [N_REQ-1:0] acc;
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (q[i].size() > 0) begin
          in_valid[i]        = 1'b1;
          in_last[i]         = q[i][0].l;
          in_data[8*i +: 8]  = q[i][0].d;
        end else begin
          in_valid[i]        = 1'b0;
          in_last[i]         = 1'b0;
          in_data[8*i +: 8]  = 8'h00;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t             e;
    logic [N_REQ-1:0] allowed;
    cycle++;
    if (!rst_n) begin
      checkOutput("reset_outputs", {tx_req, grant_valid, busy, in_ready, tx_data}, 0);
      prev_req = 1'b0;
    end else begin
      allowed = (grant_valid && tx_ready && in_valid[grant]) ? (N_REQ'(1) << grant) : '0;
      checkOutput("busy_vs_grant_valid", busy, grant_valid);
      checkOutput("in_ready_illegal_bits", in_ready & ~allowed, 0);
      if (tx_req) begin
        checkOutput("req_while_not_ready", tx_ready, 1);
        checkOutput("req_longer_than_one", prev_req, 0);
        if (last_req_cycle >= 0)
          checkOutput("req_gap_ge_frame", (cycle - last_req_cycle) >= MIN_GAP, 1);
        last_req_cycle = cycle;
        grant_log.push_back(8'(grant));
        if (expq.size() == 0) begin
          checkOutput("unexpected_req", 1, 0);
        end else begin
          e = expq.pop_front();
          checkOutput("tx_grant", grant, e.g);
          checkOutput("tx_data", tx_data, e.d);
        end
      end
      prev_req = tx_req;
    end
  end

  task automatic start_test();
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) q[i].delete();
    grant_log.delete();
    frames.delete();
    expq.delete();
  endtask

  task automatic release_reset();
    build_expected();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      done = !grant_valid && tx_ready;
      for (int i = 0; i < N_REQ; i++) if (q[i].size() > 0) done = 1'b0;
    end
    checkOutput({name, "_idle"}, done, 1);
    repeat (4) @(negedge clk);
    checkOutput({name, "_exp_drained"}, expq.size(), 0);
  endtask

  task automatic wait_ready(input logic level, input string name);
    int n = 0;
    while (tx_ready !== level && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, tx_ready, level);
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int ct_bytes [4] = '{8'h11, 8'h12, 8'h21, 8'h22};
    int ct_gnts  [4] = '{0, 0, 2, 2};
    int fr_bytes [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hA4, 8'hA5};
    int fr_gnts  [6] = '{1, 1, 1, 3, 1, 1};
    int n, hold, npk, len;

    // Single byte from requester 0.
    start_test();
    applyStimulus(0, 8'h41, 1'b1);
    release_reset();
    wait_ready(1'b0, "sb_frame_started");
    wait_ready(1'b1, "sb_frame_done");
    checkOutput("sb_grant_held_at_ready", grant_valid, 1);
    @(negedge clk);
    checkOutput("sb_grant_dropped_after_ready", grant_valid, 0);
    wait_idle(500, "sb");
    checkOutput("sb_frame_count", frames.size(), 1);
    if (frames.size() > 0) checkOutput("sb_frame_bits", int'(frames[0]), 10'b1010000010);

    // Contention between requesters 0 and 2.
    start_test();
    applyStimulus(0, 8'h11, 1'b0);
    applyStimulus(0, 8'h12, 1'b1);
    applyStimulus(2, 8'h21, 1'b0);
    applyStimulus(2, 8'h22, 1'b1);
    release_reset();
    wait_idle(2000, "ct");
    checkOutput("ct_frame_count", frames.size(), 4);
    checkOutput("ct_grant_count", grant_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < frames.size()) checkOutput($sformatf("ct_line_byte%0d", k), frames[k][8:1], ct_bytes[k]);
      if (k < grant_log.size()) checkOutput($sformatf("ct_grant%0d", k), grant_log[k], ct_gnts[k]);
    end

    // Burst cap: requester 1 streams five bytes, requester 3 waits.
    start_test();
    for (int k = 1; k <= 5; k++) applyStimulus(1, 8'hA0 + 8'(k), k == 5);
    applyStimulus(3, 8'hB1, 1'b1);
    release_reset();
    wait_idle(3000, "fr");
    checkOutput("fr_frame_count", frames.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < frames.size()) checkOutput($sformatf("fr_line_byte%0d", k), frames[k][8:1], fr_bytes[k]);
      if (k < grant_log.size()) checkOutput($sformatf("fr_grant%0d", k), grant_log[k], fr_gnts[k]);
    end

    // Hold timeout: requester 0 leaves its packet open.
    start_test();
    applyStimulus(0, 8'h5A, 1'b0);
    applyStimulus(1, 8'h3C, 1'b1);
    release_reset();
    wait_ready(1'b0, "to_frame_started");
    wait_ready(1'b1, "to_frame_done");
    hold = 0;
    n    = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (!grant_valid) break;
      hold++;
    end
    checkOutput("to_hold_cycles", hold, HOLD_TIMEOUT);
    n = 0;
    while (!grant_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_next_grant_valid", grant_valid, 1);
    checkOutput("to_next_grant", grant, 1);
    wait_idle(500, "to");

    // Reset while waiting for the transceiver.
    start_test();
    applyStimulus(0, 8'h55, 1'b0);
    applyStimulus(0, 8'h66, 1'b1);
    applyStimulus(2, 8'h77, 1'b1);
    release_reset();
    n = 0;
    while (!(grant_valid && !tx_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rm_reached_wait", grant_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rm_async_grant_valid", grant_valid, 0);
    checkOutput("rm_async_tx_req", tx_req, 0);
    checkOutput("rm_async_in_ready", in_ready, 0);
    checkOutput("rm_async_busy", busy, 0);
    release_reset();
    n = 0;
    while (!grant_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rm_regrant_valid", grant_valid, 1);
    checkOutput("rm_first_grant", grant, 0);
    wait_idle(1000, "rm");

    // Randomized packet mixes checked against the model.
    for (int r = 0; r < 6; r++) begin
      start_test();
      for (int i = 0; i < N_REQ; i++) begin
        if ($urandom_range(0, 9) < 6) begin
          npk = $urandom_range(1, 3);
          for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++)
              applyStimulus(i, 8'($urandom), (b == len - 1) && ($urandom_range(0, 7) != 0));
          end
        end
      end
      release_reset();
      wait_idle(8000, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
